single_ram_ctrl: RTL

Burst-capable bus master that drives the single-port RAM interface (addr, tri-state data, cs, we, oe) on behalf of a host.
- Host side: a request channel (valid/ready), a write-data stream, and a read-data stream.
- Block sequences RAM write and read cycles with incrementing, wrapping addresses.
- Block owns the bidirectional data bus direction and inserts a turnaround cycle after every read burst.
- Sits between a host or DMA engine and one RAM instance on the same clock.

---
 rtl/single_ram_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/single_ram_ctrl.sv
// Single-port RAM bus master: runs host write/read bursts with wrapping
// addresses, owns the tri-state data bus and adds a turnaround after reads.
module single_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [1:0] {IDLE, WR, RD, TA} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_WIDTH-1:0]  beats_reg, beats_next;
    logic                  drive_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            beats_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            beats_reg <= beats_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        beats_next = beats_reg;
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_oe     = 1'b0;
        ram_addr   = '0;
        drive_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                req_ready = rst_n;
                if (req_valid) begin
                    addr_next  = req_addr;
                    beats_next = req_len;
                    state_next = req_we ? WR : RD;
                end
            end
            WR: begin
                // write strobe held; chip select alone gates each beat
                wr_ready = 1'b1;
                ram_we   = 1'b1;
                ram_cs   = wr_valid;
                ram_addr = addr_reg;
                drive_en = 1'b1;
                if (wr_valid) begin
                    addr_next  = addr_reg + 1'b1;
                    beats_next = beats_reg - 1'b1;
                    if (beats_reg == '0)
                        state_next = IDLE;
                end
            end
            RD: begin
                ram_cs     = 1'b1;
                ram_oe     = 1'b1;
                ram_addr   = addr_reg;
                addr_next  = addr_reg + 1'b1;
                beats_next = beats_reg - 1'b1;
                if (beats_reg == '0)
                    state_next = TA;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_data = drive_en ? wr_data : {DATA_WIDTH{1'bz}};

    // read beat is captured at the end of its address cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= (state_reg == RD);
            rd_last  <= (state_reg == RD) && (beats_reg == '0);
            if (state_reg == RD)
                rd_data <= ram_data;
        end
    end

endmodule
